// File: rtl/fp_intcast_pkg.sv
// Shared definitions for the integer-to-float cast blocks: the rounding-mode
// enum, the BF16 format constants and the IEEE exception status struct.
package fp_intcast_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 7;
    localparam int BIAS   = 127;
    localparam int BF16_W = 16;

    typedef enum logic [2:0] {
        RND_RNE = 3'd0,
        RND_RTZ = 3'd1,
        RND_RDN = 3'd2,
        RND_RUP = 3'd3,
        RND_RMM = 3'd4
    } rnd_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    // Encodings 5..7 are reserved and behave as round-to-nearest-even.
    function automatic rnd_e decode_rnd(input logic [2:0] code);
        rnd_e mode;
        case (code)
            3'd1:    mode = RND_RTZ;
            3'd2:    mode = RND_RDN;
            3'd3:    mode = RND_RUP;
            3'd4:    mode = RND_RMM;
            default: mode = RND_RNE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/fp_intcast_lzc.sv
// Combinational leading-zero counter. For an all-zero input the count is W
// and zero_o is raised.
module fp_intcast_lzc #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_s;
    logic          found_s;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        cnt_s   = CW'(W);
        found_s = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found_s && data_i[i]) begin
                cnt_s   = CW'(W - 1 - i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign cnt_o  = cnt_s;
    assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_intcast_i2f_bf16.sv
// Integer (signed/unsigned) to BF16 converter, two-stage valid/ready pipeline.
// Stage 1: sign, magnitude, leading-zero count, normalisation.
// Stage 2: rounding, exponent carry adjust, packing into the output register.
// Optional feature: define FP_INTCAST_I2F_STATUS_EN to add the out_status port.
module fp_intcast_i2f_bf16
    import fp_intcast_pkg::*;
#(
    parameter int INT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_data,
    input  logic                 in_signed,
    input  logic [2:0]           in_rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BF16_W-1:0]    out_data
`ifdef FP_INTCAST_I2F_STATUS_EN
    ,
    output logic [4:0]           out_status
`endif
);

    localparam int CW = $clog2(INT_WIDTH + 1);

    // Stage-1 combinational signals
    logic                 sign_s;
    logic [INT_WIDTH-1:0] abs_s;
    logic [CW-1:0]        lz_s;
    logic                 zero_s;
    logic [INT_WIDTH-1:0] norm_s;
    logic [EXP_W-1:0]     exp_s;

    // Stage-1 registers
    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic                 s1_zero_q;
    logic [EXP_W-1:0]     s1_exp_q;
    logic [INT_WIDTH-1:0] s1_norm_q;
    rnd_e                 s1_rnd_q;

    // Stage-2 combinational signals
    logic [INT_WIDTH+1:0] ext_s;
    logic [MAN_W:0]       sig_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 inc_s;
    logic [MAN_W+1:0]     sum_s;
    logic [BF16_W-1:0]    res_d;

    // Output registers
    logic                 out_valid_q;
    logic [BF16_W-1:0]    out_data_q;

    // Handshake
    logic                 s2_adv_s;
    logic                 s1_adv_s;

    assign s2_adv_s = !out_valid_q || out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;
    assign in_ready = s1_adv_s;

    fp_intcast_lzc #(
        .W  (INT_WIDTH),
        .CW (CW)
    ) u_lzc (
        .data_i (abs_s),
        .cnt_o  (lz_s),
        .zero_o (zero_s)
    );

    // Stage 1: magnitude (most negative value maps to 2^(W-1) unsigned) and normalise.
    always_comb begin
        sign_s = in_signed & in_data[INT_WIDTH-1];
        if (sign_s) begin
            abs_s = ~in_data + INT_WIDTH'(1);
        end else begin
            abs_s = in_data;
        end
        norm_s = abs_s << lz_s;
        exp_s  = EXP_W'(BIAS + INT_WIDTH - 1) - EXP_W'(lz_s);
    end

    // Stage 2: round the 8-bit significand with guard/sticky, fold carry into exponent.
    always_comb begin
        ext_s    = {s1_norm_q, 2'b00};
        sig_s    = ext_s[INT_WIDTH+1 -: MAN_W+1];
        guard_s  = ext_s[INT_WIDTH-7];
        sticky_s = |ext_s[INT_WIDTH-8:0];
        case (s1_rnd_q)
            RND_RNE: inc_s = guard_s & (sticky_s | sig_s[0]);
            RND_RTZ: inc_s = 1'b0;
            RND_RDN: inc_s = s1_sign_q & (guard_s | sticky_s);
            RND_RUP: inc_s = !s1_sign_q & (guard_s | sticky_s);
            RND_RMM: inc_s = guard_s;
            default: inc_s = guard_s & (sticky_s | sig_s[0]);
        endcase
        sum_s = {1'b0, sig_s} + (MAN_W + 2)'(inc_s);
        if (s1_zero_q) begin
            res_d = 16'h0000;
        end else if (sum_s[MAN_W+1]) begin
            res_d = {s1_sign_q, s1_exp_q + 8'd1, 7'd0};
        end else begin
            res_d = {s1_sign_q, s1_exp_q, sum_s[MAN_W-1:0]};
        end
    end

    // Pipeline registers: each stage loads when empty or when its consumer drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b1;
            s1_exp_q    <= 8'd0;
            s1_norm_q   <= '0;
            s1_rnd_q    <= RND_RNE;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
        end else begin
            if (s1_adv_s) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && s1_adv_s) begin
                s1_sign_q <= sign_s;
                s1_zero_q <= zero_s;
                s1_exp_q  <= exp_s;
                s1_norm_q <= norm_s;
                s1_rnd_q  <= decode_rnd(in_rnd);
            end
            if (s2_adv_s) begin
                out_valid_q <= s1_valid_q;
            end
            if (s1_valid_q && s2_adv_s) begin
                out_data_q <= res_d;
            end
        end
    end

`ifdef FP_INTCAST_I2F_STATUS_EN
    status_t status_d;
    status_t status_q;

    // Only inexact can be raised by an integer-to-BF16 conversion.
    always_comb begin
        status_d    = '0;
        status_d.nx = (guard_s | sticky_s) & !s1_zero_q;
    end

    // Status travels with the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else if (s1_valid_q && s2_adv_s) begin
            status_q <= status_d;
        end
    end

    assign out_status = status_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_intcast_i2f_bf16.sv
// Directed and streaming checks for fp_intcast_i2f_bf16 (INT_WIDTH = 16).
module tb_fp_intcast_i2f_bf16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_signed;
    logic [2:0]  in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef FP_INTCAST_I2F_STATUS_EN
    logic [4:0]  out_status;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fp_intcast_i2f_bf16 #(.INT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FP_INTCAST_I2F_STATUS_EN
        ,
        .out_status(out_status)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: exponent from log2, remainder compared against half-ulp.
    function automatic logic [15:0] ref_bf16(input logic [15:0] d, input logic sg, input logic [2:0] rm);
        logic        neg;
        int unsigned m, sig, rem, half;
        int          e;
        logic        inc;
        logic [7:0]  ex;
        neg = sg && d[15];
        m   = neg ? (32'h10000 - {16'd0, d}) : {16'd0, d};
        if (m == 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 17; i++) if (m >= (32'd1 << i)) e = i;
        if (e >= 7) begin
            sig  = m >> (e - 7);
            rem  = m - (sig << (e - 7));
            half = (e >= 8) ? (32'd1 << (e - 8)) : 32'd0;
        end else begin
            sig  = m << (7 - e);
            rem  = 0;
            half = 0;
        end
        case ((rm > 3'd4) ? 3'd0 : rm)
            3'd0:    inc = (half != 0) && ((rem > half) || ((rem == half) && sig[0]));
            3'd1:    inc = 1'b0;
            3'd2:    inc = neg && (rem != 0);
            3'd3:    inc = !neg && (rem != 0);
            default: inc = (half != 0) && (rem >= half);
        endcase
        sig = sig + {31'd0, inc};
        if (sig == 256) begin
            sig = 128;
            e   = e + 1;
        end
        ex = 8'(127 + e);
        return {neg, ex, sig[6:0]};
    endfunction

    // Drive one operand with out_ready high; report result, status and edges to out_valid.
    task automatic convert(input logic [15:0] d, input logic sg, input logic [2:0] rm,
                           output logic [15:0] res, output logic [4:0] st, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = sg;
        in_rnd    = rm;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_data;
        st  = 5'd0;
`ifdef FP_INTCAST_I2F_STATUS_EN
        st = out_status;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; in_signed = 1'b0;
        in_rnd = 3'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_signed_basic();
        logic [15:0] vin [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0000};
        logic [15:0] vexp[4] = '{16'h3F80, 16'hBF80, 16'hC700, 16'h0000};
        logic [15:0] res; logic [4:0] st; int lat;
        for (int i = 0; i < 4; i++) begin
            convert(vin[i], 1'b1, 3'd0, res, st, lat);
            n_checks++;
            if (res !== vexp[i]) begin n_fail++; $display("FAIL signed_basic[%0d] got=%h exp=%h", i, res, vexp[i]); end
            n_checks++;
            if (lat != 2) begin n_fail++; $display("FAIL latency[%0d] got=%0d exp=2", i, lat); end
        end
        // Zero in every rounding mode, unsigned too
        for (int m = 0; m < 8; m++) begin
            convert(16'h0000, m[0], 3'(m), res, st, lat);
            n_checks++;
            if (res !== 16'h0000) begin n_fail++; $display("FAIL zero_mode%0d got=%h exp=0000", m, res); end
        end
    endtask

    task automatic test_round_carry();
        logic [15:0] res; logic [4:0] st; int lat;
        convert(16'hFFFF, 1'b0, 3'd0, res, st, lat);
        n_checks++;
        if (res !== 16'h4780) begin n_fail++; $display("FAIL carry_rne got=%h exp=4780", res); end
`ifdef FP_INTCAST_I2F_STATUS_EN
        n_checks++;
        if (st !== 5'b00001) begin n_fail++; $display("FAIL carry_nx got=%b exp=00001", st); end
`endif
        convert(16'hFFFF, 1'b0, 3'd1, res, st, lat);
        n_checks++;
        if (res !== 16'h477F) begin n_fail++; $display("FAIL carry_rtz got=%h exp=477F", res); end
    endtask

    task automatic test_ties();
        logic [15:0] vin [4] = '{16'd257, 16'd257, 16'd259, 16'd256};
        logic [2:0]  vrm [4] = '{3'd0, 3'd3, 3'd0, 3'd0};
        logic [15:0] vexp[4] = '{16'h4380, 16'h4381, 16'h4382, 16'h4380};
        logic [15:0] res; logic [4:0] st; int lat;
        for (int i = 0; i < 4; i++) begin
            convert(vin[i], 1'b0, vrm[i], res, st, lat);
            n_checks++;
            if (res !== vexp[i]) begin n_fail++; $display("FAIL ties[%0d] got=%h exp=%h", i, res, vexp[i]); end
        end
`ifdef FP_INTCAST_I2F_STATUS_EN
        n_checks++;
        if (st !== 5'b00000) begin n_fail++; $display("FAIL exact_nx got=%b exp=00000", st); end
`endif
    endtask

    task automatic test_signed_dir();
        logic [2:0]  vrm [5] = '{3'd2, 3'd3, 3'd6, 3'd1, 3'd4};
        logic [15:0] vexp[5] = '{16'hC381, 16'hC380, 16'hC380, 16'hC380, 16'hC381};
        logic [15:0] res; logic [4:0] st; int lat;
        for (int i = 0; i < 5; i++) begin
            convert(16'hFEFF, 1'b1, vrm[i], res, st, lat);
            n_checks++;
            if (res !== vexp[i]) begin n_fail++; $display("FAIL neg257[%0d] got=%h exp=%h", i, res, vexp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        logic [15:0] d, prev_data, e;
        logic        sg, prev_stall, in_fire, out_fire;
        logic [2:0]  rm;
        int sent = 0, recv = 0, cyc = 0;
        prev_stall = 1'b0; prev_data = 16'h0;
        d = 16'h1234; sg = 1'b0; rm = 3'd0;
        while (recv < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 100);
            in_data   = d; in_signed = sg; in_rnd = rm;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++; $display("FAIL stall_stable valid=%b data=%h exp 1/%h", out_valid, out_data, prev_data);
                end
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL stream[%0d] got=%h exp=%h", recv, out_data, e); end
                end
                recv++;
            end
            if (in_fire) begin
                exp_q.push_back(ref_bf16(d, sg, rm));
                sent++;
                case ($urandom_range(0, 9))
                    0:       d = 16'h8000;
                    1:       d = 16'h0000;
                    default: d = 16'($urandom);
                endcase
                sg = 1'($urandom);
                rm = 3'($urandom);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sent != 100 || recv != 100 || exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_count sent=%0d recv=%0d left=%0d exp 100/100/0", sent, recv, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b0; in_rnd = 3'd0; in_data = 16'd1;
        @(negedge clk);
        in_data = 16'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_pipe out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
            n_fail++; $display("FAIL async_reset out_valid=%b in_ready=%b data=%h exp 0/1/0000", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL stale_result got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_round_carry();
        test_ties();
        test_signed_dir();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_intcast_i2f_bf16.md
FP_INTCAST_I2F_BF16 -- requirements
Module: fp_intcast_i2f_bf16

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 16, integer source width, legal range 8..32.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  source operand valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-006 SHALL have port in_data  input  INT_WIDTH  integer operand.
REQ-007 SHALL have port in_signed  input  1  1 = two's-complement, 0 = unsigned.
REQ-008 SHALL have port in_rnd  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  sink accepts result.
REQ-011 SHALL have port out_data  output  16  BF16 result (1 sign, 8 exp bias 127, 7 mantissa).
REQ-012 SHALL have port out_status  output  5  {NV,DZ,OF,UF,NX}, present only when the REQ-030 macro is defined.

Function
REQ-013 SHALL convert in_data to BF16 per in_rnd; a transfer occurs when valid and ready are both high at a rising edge of clk.
REQ-014 SHALL be a two-stage pipeline: stage 1 sign extraction, absolute value, leading-zero count, normalisation; stage 2 rounding, exponent adjust, packing.
REQ-015 SHALL have latency exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-016 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-017 SHALL advance each stage when it is empty or its downstream stage transfers; in_ready = !s1_valid || s1_advances, combinational from out_ready.
REQ-018 SHALL hold out_data, out_status and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL never drop or duplicate an operand under any in_valid/out_ready pattern, including simultaneous input and output transfer with both stages full.
REQ-020 SHALL produce 0x0000 for zero input in every mode; negative zero never occurs.
REQ-021 SHALL treat in_data[INT_WIDTH-1] as sign only when in_signed = 1; the most negative signed value SHALL convert exactly.
REQ-022 SHALL round the 8-bit significand using guard and sticky bits; RDN/RUP SHALL be applied against the result sign.
REQ-023 SHALL increment the exponent and clear the mantissa on a rounding carry-out.
REQ-024 SHALL treat in_rnd values 5..7 as RNE.
REQ-025 SHALL never produce overflow, infinity or NaN; the maximum exponent for INT_WIDTH <= 32 is 159.

Reset
REQ-026 SHALL, while rst_n is low, clear both stage valid flags asynchronously; out_valid = 0, out_data = 0x0000, out_status = 0.
REQ-027 SHALL drive in_ready = 1 during and immediately after reset.
REQ-028 SHALL discard in-flight operands on reset assertion mid-operation; no result for them appears after release.
REQ-029 SHALL reset only control and valid flags asynchronously; datapath registers need not be reset, but out_data must still read 0 while out_valid = 0 after reset.

Configuration
REQ-030 SHALL, with FP_INTCAST_I2F_STATUS_EN defined, provide out_status with NX = guard|sticky and NV, DZ, OF, UF = 0, pipelined alongside out_data.
REQ-031 SHALL, without FP_INTCAST_I2F_STATUS_EN, omit the out_status port and its pipeline registers; out_data SHALL be identical in both builds.

Structure
REQ-032 SHALL take the following from shared package fp_intcast_pkg: the rounding-mode enum (RNE..RMM), BF16 constants (EXP_W 8, MAN_W 7, BIAS 127), and the status struct.
REQ-033 SHALL instantiate one sub-module, fp_intcast_lzc: parameterised leading-zero counter, combinational, with an all-zero flag.

Verification
REQ-034 SHALL cover, with signed and out_ready = 1: 1 -> 0x3F80; -1 -> 0xBF80; 0x8000 -> 0xC700; 0 -> 0x0000; each out_valid exactly 2 cycles after the transfer.
REQ-035 SHALL cover unsigned 0xFFFF: RNE -> 0x4780 (carry into exponent, NX = 1); RTZ -> 0x477F.
REQ-036 SHALL cover ties on unsigned inputs: 257 with RNE -> 0x4380, RUP -> 0x4381; 259 with RNE -> 0x4382; 256 -> 0x4380 with NX = 0.
REQ-037 SHALL cover signed -257: RDN -> 0xC381, RUP -> 0xC380; in_rnd = 6 SHALL give the RNE result 0xC380.
REQ-038 SHALL cover a 100-operand back-to-back stream with random out_ready stalls: results match a reference model in order; no loss or duplication; outputs stable during stalls.
REQ-039 SHALL cover rst_n asserted with both stages full: out_valid falls immediately, in_ready = 1, and no stale result appears after release.
